// File: rtl/led_frame_ctrl.sv
// Purpose : double-buffered LED frame scheduler; I2C write bytes in, encoder byte stream out.
// Latency : STOP at clk N -> tx_valid_o from N+2; frame_done_o LATCH_CYCLES clks after last byte accepted.
// Backpressure: tx_ready_i low holds tx_data_o stable indefinitely; rx side is never stalled (bytes dropped past NBYTES).
// Ports:
//   clk, reset (async active-low)
//   rx_start_i / rx_valid_i / rx_data_i / rx_stop_i : byte-receiver pulses
//   tx_data_o / tx_valid_o / tx_ready_i / tx_last_o : encoder valid/ready stream
//   busy_o, frame_done_o, overflow_o                : status
module led_frame_ctrl #(
    parameter int LED_CNT       = 3,
    parameter int BYTES_PER_LED = 3,
    parameter int LATCH_CYCLES  = 2500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_start_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_stop_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       tx_last_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       overflow_o
);

    localparam int NBYTES = LED_CNT * BYTES_PER_LED;
    localparam int PTR_W  = $clog2(NBYTES + 1);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES + 1) : 1;

    localparam logic [PTR_W-1:0] NB_P     = PTR_W'(NBYTES);
    localparam logic [PTR_W-1:0] LAST_P   = PTR_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        LATCH  = 2'd2
    } state_t;

    state_t           state;
    logic [7:0]       mem [2][NBYTES];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             disp_bank;
    logic             pending;

    // Write-side next-state: a start in the same cycle as a byte rebases the byte to index 0.
    logic [PTR_W-1:0] base_ptr;
    logic [PTR_W-1:0] next_ptr;
    logic             wr_en;
    logic             ovf_hit;
    logic             commit;

    always_comb begin
        base_ptr = rx_start_i ? '0 : wr_ptr;
        wr_en    = rx_valid_i && (base_ptr < NB_P);
        ovf_hit  = rx_valid_i && (base_ptr >= NB_P);
        next_ptr = wr_en ? base_ptr + 1'b1 : base_ptr;
        // A STOP only commits if the transaction delivered at least one byte.
        commit   = rx_stop_i && (next_ptr != '0);
    end

    // Write side always fills the bank that is not on display.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            overflow_o <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NBYTES; i++) begin
                    mem[b][i] <= 8'h00;
                end
            end
        end else begin
            wr_ptr <= next_ptr;
            if (rx_start_i) begin
                overflow_o <= 1'b0;
            end
            if (ovf_hit) begin
                overflow_o <= 1'b1;
            end
            if (wr_en) begin
                mem[~disp_bank][base_ptr[IDX_W-1:0]] <= rx_data_i;
            end
        end
    end

    // Frame FSM. A commit arriving mid-stream only sets pending; the swap waits for IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            cnt       <= '0;
            disp_bank <= 1'b0;
            pending   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        disp_bank <= ~disp_bank;
                        rd_ptr    <= '0;
                        pending   <= 1'b0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (tx_ready_i) begin
                        if (rd_ptr == LAST_P) begin
                            cnt   <= CNT_INIT;
                            state <= LATCH;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                LATCH: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // A new commit outranks the clear from a swap in the same cycle.
            if (commit) begin
                pending <= 1'b1;
            end
        end
    end

    // Outputs decode registered state only; reset forces all of them to zero.
    always_comb begin
        tx_valid_o   = (state == STREAM);
        tx_data_o    = (state == STREAM) ? mem[disp_bank][rd_ptr[IDX_W-1:0]] : 8'h00;
        tx_last_o    = (state == STREAM) && (rd_ptr == LAST_P);
        frame_done_o = (state == LATCH) && (cnt == '0);
        busy_o       = (state != IDLE) || pending;
    end

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Purpose : self-checking bench for led_frame_ctrl with a double-buffer reference model.
// Latency : checks STOP->valid of 2 clks and last-accept->frame_done of LATCH_CYCLES clks.
// Backpressure: drives tx_ready_i steady, toggling and random; checks stall stability.
module tb_led_frame_ctrl;

    localparam int NB  = 9;
    localparam int LAT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_start_i = 1'b0;
    logic       rx_valid_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       rx_stop_i = 1'b0;
    logic       tx_ready_i = 1'b1;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_last_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       overflow_o;

    led_frame_ctrl #(.LED_CNT(3), .BYTES_PER_LED(3), .LATCH_CYCLES(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_start_i   (rx_start_i),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .rx_stop_i    (rx_stop_i),
        .tx_data_o    (tx_data_o),
        .tx_valid_o   (tx_valid_o),
        .tx_ready_i   (tx_ready_i),
        .tx_last_o    (tx_last_o),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model: two banks, one on display ----------------
    logic [7:0] mbank [2][NB];
    int         mdisp;
    logic [7:0] exp_frame [NB];
    logic [7:0] frm [$];
    int         stop_cyc;

    function automatic void model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NB; i++) mbank[b][i] = 8'h00;
        mdisp = 0;
    endfunction

    // The frame that will be shown next is whatever the hidden bank holds at swap time.
    function automatic void model_take();
        for (int i = 0; i < NB; i++) exp_frame[i] = mbank[1-mdisp][i];
        mdisp = 1 - mdisp;
    endfunction

    function automatic void fill_rand(input int n);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(8'($urandom_range(0, 255)));
    endfunction

    // ---------------- output monitor ----------------
    logic [7:0] got_dat [$];
    bit         got_last [$];
    int         done_lat [$];
    int         last_acc_cyc = 0;
    int         valid_rise_cyc = -1;
    int         valid_cycles = 0;
    int         stall_err = 0;
    int         stall_cnt = 0;
    logic       pv = 1'b0;
    logic       pstall = 1'b0;
    logic [7:0] pdat = 8'h00;

    always @(negedge clk) begin
        #2;
        if (reset) begin
            if (pstall && !(tx_valid_o === 1'b1 && tx_data_o === pdat)) stall_err++;
            if (tx_valid_o && !pv) valid_rise_cyc = cyc;
            if (tx_valid_o) valid_cycles++;
            if (tx_valid_o && tx_ready_i) begin
                got_dat.push_back(tx_data_o);
                got_last.push_back(tx_last_o);
                if (tx_last_o) last_acc_cyc = cyc;
            end
            if (frame_done_o) done_lat.push_back(cyc - last_acc_cyc);
            pstall = tx_valid_o && !tx_ready_i;
            if (pstall) stall_cnt++;
            pdat = tx_data_o;
            pv   = tx_valid_o;
        end else begin
            pv     = 1'b0;
            pstall = 1'b0;
        end
    end

    function automatic void clear_mon();
        got_dat.delete();
        got_last.delete();
        done_lat.delete();
        valid_cycles = 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_frame(input bit merge);
        int i;
        i = 0;
        @(negedge clk);
        rx_start_i = 1'b1;
        if (merge && frm.size() > 0) begin
            rx_valid_i = 1'b1;
            rx_data_i  = frm[0];
            i = 1;
        end
        @(negedge clk);
        rx_start_i = 1'b0;
        rx_valid_i = 1'b0;
        while (i < frm.size()) begin
            rx_valid_i = 1'b1;
            rx_data_i  = frm[i];
            i++;
            @(negedge clk);
            rx_valid_i = 1'b0;
        end
        rx_stop_i = 1'b1;
        stop_cyc  = cyc;
        @(negedge clk);
        rx_stop_i = 1'b0;
        for (int k = 0; k < frm.size() && k < NB; k++) mbank[1-mdisp][k] = frm[k];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        clear_mon();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits for one full frame plus its frame_done, then compares it with exp_frame.
    task automatic wait_frame(input string name, input int mode);
        int t;
        t = 0;
        while ((got_dat.size() < NB || done_lat.size() < 1) && t < 2000) begin
            @(negedge clk);
            case (mode)
                1:       tx_ready_i = ~tx_ready_i;
                2:       tx_ready_i = 1'($urandom_range(0, 1));
                default: tx_ready_i = 1'b1;
            endcase
            t++;
        end
        @(negedge clk);
        tx_ready_i = 1'b1;
        checks++;
        if (t >= 2000) begin
            errors++;
            $display("FAIL %s timeout: got %0d bytes, %0d done pulses, required %0d and 1",
                     name, got_dat.size(), done_lat.size(), NB);
        end else begin
            for (int i = 0; i < NB; i++) begin
                checks++;
                if (got_dat[0] !== exp_frame[i]) begin
                    errors++;
                    $display("FAIL %s byte[%0d]: got %02h required %02h", name, i, got_dat[0], exp_frame[i]);
                end
                checks++;
                if (got_last[0] !== (i == NB - 1)) begin
                    errors++;
                    $display("FAIL %s last[%0d]: got %0b required %0b", name, i, got_last[0], (i == NB - 1));
                end
                void'(got_dat.pop_front());
                void'(got_last.pop_front());
            end
            checks++;
            if (done_lat[0] !== LAT) begin
                errors++;
                $display("FAIL %s done_latency: got %0d required %0d", name, done_lat[0], LAT);
            end
            void'(done_lat.pop_front());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int t;
        model_reset();
        @(negedge clk);
        #2;
        checks++;
        if ({tx_valid_o, busy_o, tx_last_o, frame_done_o, overflow_o, tx_data_o} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v%0b b%0b l%0b d%0b o%0b data %02h required all 0",
                     tx_valid_o, busy_o, tx_last_o, frame_done_o, overflow_o, tx_data_o);
        end
        @(negedge clk);
        reset = 1'b1;
        fill_rand(NB);
        send_frame(1'b0);
        model_take();
        t = 0;
        while (got_dat.size() < 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL reset_prestream: got %0d bytes required 3", got_dat.size());
        end
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || tx_data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_midstream: got v%0b b%0b data %02h required 0 0 00",
                     tx_valid_o, busy_o, tx_data_o);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        clear_mon();
        idle(30);
        checks++;
        if (valid_cycles !== 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: got %0d valid cycles busy %0b required 0 0", valid_cycles, busy_o);
        end
    endtask

    task automatic test_full_frame();
        logic [7:0] v [NB];
        v = '{8'h8E, 8'hA8, 8'hA8, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        frm.delete();
        for (int i = 0; i < NB; i++) frm.push_back(v[i]);
        valid_rise_cyc = -1;
        send_frame(1'b0);
        model_take();
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL full_no_overflow: got %0b required 0", overflow_o);
        end
        wait_frame("full_frame", 0);
        checks++;
        if (valid_rise_cyc - stop_cyc !== 2) begin
            errors++;
            $display("FAIL stop_to_valid: got %0d clks required 2", valid_rise_cyc - stop_cyc);
        end
        idle(4);
    endtask

    task automatic test_backpressure();
        stall_err = 0;
        stall_cnt = 0;
        fill_rand(NB);
        send_frame(1'b1);
        model_take();
        wait_frame("bp_toggle", 1);
        idle(3);
        fill_rand(NB);
        send_frame(1'b0);
        model_take();
        wait_frame("bp_random", 2);
        idle(30);
        checks++;
        if (got_dat.size() !== 0) begin
            errors++;
            $display("FAIL bp_extra_bytes: got %0d required 0", got_dat.size());
        end
        checks++;
        if (stall_err !== 0 || stall_cnt == 0) begin
            errors++;
            $display("FAIL bp_stall_stable: got %0d unstable of %0d stalls required 0 of >0", stall_err, stall_cnt);
        end
    endtask

    task automatic test_overflow();
        fill_rand(NB + 2);
        send_frame(1'b0);
        model_take();
        checks++;
        if (overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %0b required 1", overflow_o);
        end
        wait_frame("overflow_frame", 0);
        checks++;
        if (overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %0b required 1", overflow_o);
        end
        @(negedge clk);
        rx_start_i = 1'b1;
        @(negedge clk);
        rx_start_i = 1'b0;
        #2;
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: got %0b required 0", overflow_o);
        end
        idle(4);
    endtask

    task automatic test_partial();
        do_reset();
        frm.delete();
        for (int i = 1; i <= NB; i++) frm.push_back(8'(i));
        send_frame(1'b0);
        model_take();
        wait_frame("partial_A", 0);
        frm.delete();
        frm.push_back(8'hAA);
        frm.push_back(8'hBB);
        send_frame(1'b0);
        model_take();
        wait_frame("partial_B", 0);
        // A STOP with no bytes must not start anything.
        frm.delete();
        send_frame(1'b0);
        idle(5);
        checks++;
        if (busy_o !== 1'b0 || got_dat.size() !== 0) begin
            errors++;
            $display("FAIL empty_stop: got busy %0b bytes %0d required 0 0", busy_o, got_dat.size());
        end
    endtask

    task automatic test_commit_during_stream();
        int t;
        fill_rand(NB);
        send_frame(1'b0);
        model_take();
        t = 0;
        while (got_dat.size() < 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        tx_ready_i = 1'b0;
        checks++;
        if (t >= 100) begin
            errors++;
            $display("FAIL commit_prestream: got %0d bytes required 2", got_dat.size());
        end
        fill_rand(NB);
        send_frame(1'b0);
        fill_rand(NB);
        send_frame(1'b0);
        checks++;
        if (busy_o !== 1'b1 || tx_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL commit_stalled: got busy %0b valid %0b required 1 1", busy_o, tx_valid_o);
        end
        wait_frame("commit_A", 0);
        model_take();
        wait_frame("commit_D", 0);
        idle(30);
        checks++;
        if (got_dat.size() !== 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL commit_only_D: got %0d extra bytes busy %0b required 0 0", got_dat.size(), busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_overflow();
        test_partial();
        test_commit_during_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
